// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD tick counter slice.
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t BCD_MAX = 4'd9;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle step strobe every DIV_COUNT enabled cycles.
module tick_prescaler #(
    parameter int unsigned DIV_COUNT = 12_000_000,
    parameter int unsigned PRESC_W   = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam logic [PRESC_W-1:0] LAST = PRESC_W'(DIV_COUNT - 1);

    logic [PRESC_W-1:0] psc;

    assign step = (psc == LAST) & en & ~clr;

    // Free-running divider: cleared by clr, frozen while en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc <= '0;
        end else if (clr) begin
            psc <= '0;
        end else if (en) begin
            if (psc == LAST) begin
                psc <= '0;
            end else begin
                psc <= psc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_tick_counter.sv
// Single-digit up/down counter with prescaled step rate, pause, synchronous
// load and tick/wrap strobes for cascading further digits.
module bcd_tick_counter
    import bcd_pkg::*;
#(
    parameter int unsigned DIV_COUNT = 12_000_000,
    parameter int unsigned MAX_DIGIT = int'(BCD_MAX),
    parameter int unsigned PRESC_W   = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       tick,
    output logic       wrap
);

    localparam digit_t MAX_D = digit_t'(MAX_DIGIT);

    digit_t digit;
    digit_t digit_next;
    logic   wrap_next;
    logic   step;

    tick_prescaler #(
        .DIV_COUNT(DIV_COUNT),
        .PRESC_W  (PRESC_W)
    ) u_presc (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (load),
        .step(step)
    );

    // Stepped digit value; out-of-range digits recover to 0 (up) or MAX (down).
    always_comb begin
        digit_next = digit;
        wrap_next  = 1'b0;
        if (up) begin
            if (digit == MAX_D) begin
                digit_next = '0;
                wrap_next  = 1'b1;
            end else if (digit > MAX_D) begin
                digit_next = '0;
            end else begin
                digit_next = digit + 1'b1;
            end
        end else begin
            if (digit == '0) begin
                digit_next = MAX_D;
                wrap_next  = 1'b1;
            end else if (digit > MAX_D) begin
                digit_next = MAX_D;
            end else begin
                digit_next = digit - 1'b1;
            end
        end
    end

    // Digit register and strobes; load overrides any coincident step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else if (load) begin
            if (load_val <= MAX_D) begin
                digit <= load_val;
            end
            tick <= 1'b0;
            wrap <= 1'b0;
        end else if (step) begin
            digit <= digit_next;
            tick  <= 1'b1;
            wrap  <= wrap_next;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
        end
    end

    assign A = digit[0];
    assign B = digit[1];
    assign C = digit[2];
    assign D = digit[3];

endmodule
